// File: rtl/set_dispatcher.sv
// Initiator for the SET en/busy/valid handshake: walks a pattern ROM, issues one job per pattern
// and checks each candidate. Optional per-job watchdog enabled by SET_DISP_TIMEOUT_EN.
module set_dispatcher #(
    parameter int unsigned NUM_PAT = 64,
    parameter int unsigned AW      = 6,
    parameter int unsigned MAX_ERR = 10,
    parameter int unsigned TIMEOUT = 4095
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start,
    input  logic [1:0]    mode,
    output logic [AW-1:0] pat_addr,
    input  logic [23:0]   pat_central,
    input  logic [11:0]   pat_radius,
    input  logic [7:0]    pat_expected,
    output logic          set_en,
    output logic [23:0]   set_central,
    output logic [11:0]   set_radius,
    output logic [1:0]    set_mode,
    input  logic          set_busy,
    input  logic          set_valid,
    input  logic [7:0]    set_candidate,
    output logic          run_busy,
    output logic          done,
    output logic          aborted,
    output logic [6:0]    err_cnt,
`ifdef SET_DISP_TIMEOUT_EN
    output logic          timeout_seen,
`endif
    output logic [AW-1:0] fail_idx
);

    localparam logic [2:0] StIdle  = 3'd0;
    localparam logic [2:0] StFetch = 3'd1;
    localparam logic [2:0] StLoad  = 3'd2;
    localparam logic [2:0] StIssue = 3'd3;
    localparam logic [2:0] StWait  = 3'd4;
    localparam logic [2:0] StCheck = 3'd5;
    localparam logic [2:0] StDone  = 3'd6;

    localparam logic [AW-1:0] LastIdx = AW'(NUM_PAT - 1);
    localparam logic [6:0]    ErrSat  = 7'd64;

    logic [2:0]    state_q, state_d;
    logic [AW-1:0] idx_q, idx_d;
    logic [AW-1:0] pat_addr_q, pat_addr_d;
    logic [23:0]   central_q, central_d;
    logic [11:0]   radius_q, radius_d;
    logic [1:0]    mode_q, mode_d;
    logic [7:0]    expected_q, expected_d;
    logic [7:0]    cand_q, cand_d;
    logic          set_en_q, set_en_d;
    logic          run_busy_q, run_busy_d;
    logic          done_q, done_d;
    logic          aborted_q, aborted_d;
    logic [6:0]    err_q, err_d;
    logic [AW-1:0] fail_q, fail_d;
    logic          mismatch;
    logic [6:0]    err_inc;

`ifdef SET_DISP_TIMEOUT_EN
    localparam int unsigned TW = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
    logic [TW-1:0] wait_cnt_q, wait_cnt_d;
    logic          job_to_q, job_to_d;
    logic          to_seen_q, to_seen_d;
    assign mismatch = (cand_q != expected_q) || job_to_q;
`else
    assign mismatch = (cand_q != expected_q);
`endif

    assign err_inc = (err_q == ErrSat) ? ErrSat : err_q + 7'd1;

    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        pat_addr_d = pat_addr_q;
        central_d  = central_q;
        radius_d   = radius_q;
        mode_d     = mode_q;
        expected_d = expected_q;
        cand_d     = cand_q;
        set_en_d   = 1'b0;
        run_busy_d = run_busy_q;
        done_d     = done_q;
        aborted_d  = aborted_q;
        err_d      = err_q;
        fail_d     = fail_q;
`ifdef SET_DISP_TIMEOUT_EN
        wait_cnt_d = wait_cnt_q;
        job_to_d   = job_to_q;
        to_seen_d  = to_seen_q;
`endif
        case (state_q)
            StIdle, StDone: begin
                if (start) begin
                    state_d    = StFetch;
                    idx_d      = '0;
                    pat_addr_d = '0;
                    err_d      = '0;
                    fail_d     = '0;
                    aborted_d  = 1'b0;
                    done_d     = 1'b0;
                    run_busy_d = 1'b1;
                    mode_d     = mode;
`ifdef SET_DISP_TIMEOUT_EN
                    to_seen_d  = 1'b0;
`endif
                end
            end
            StFetch: state_d = StLoad;
            StLoad: begin
                central_d  = pat_central;
                radius_d   = pat_radius;
                expected_d = pat_expected;
                state_d    = StIssue;
            end
            StIssue: begin
                if (!set_busy) begin
                    set_en_d = 1'b1;
                    state_d  = StWait;
`ifdef SET_DISP_TIMEOUT_EN
                    wait_cnt_d = '0;
                    job_to_d   = 1'b0;
`endif
                end
            end
            StWait: begin
                // The cycle that carries set_en never samples valid.
                if (!set_en_q) begin
                    if (set_valid) begin
                        cand_d  = set_candidate;
                        state_d = StCheck;
                    end
`ifdef SET_DISP_TIMEOUT_EN
                    else if (wait_cnt_q == TW'(TIMEOUT - 1)) begin
                        job_to_d  = 1'b1;
                        to_seen_d = 1'b1;
                        state_d   = StCheck;
                    end else begin
                        wait_cnt_d = wait_cnt_q + TW'(1);
                    end
`endif
                end
            end
            StCheck: begin
                if (mismatch) begin
                    err_d = err_inc;
                    if (err_q == 7'd0) begin
                        fail_d = idx_q;
                    end
                end
                if (mismatch && (MAX_ERR != 0) && (err_inc == 7'(MAX_ERR))) begin
                    aborted_d  = 1'b1;
                    done_d     = 1'b1;
                    run_busy_d = 1'b0;
                    state_d    = StDone;
                end else if (idx_q == LastIdx) begin
                    done_d     = 1'b1;
                    run_busy_d = 1'b0;
                    state_d    = StDone;
                end else begin
                    idx_d      = idx_q + AW'(1);
                    pat_addr_d = idx_q + AW'(1);
                    state_d    = StFetch;
                end
            end
            default: begin
                state_d    = StIdle;
                run_busy_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= StIdle;
            idx_q      <= '0;
            pat_addr_q <= '0;
            central_q  <= '0;
            radius_q   <= '0;
            mode_q     <= '0;
            expected_q <= '0;
            cand_q     <= '0;
            set_en_q   <= 1'b0;
            run_busy_q <= 1'b0;
            done_q     <= 1'b0;
            aborted_q  <= 1'b0;
            err_q      <= '0;
            fail_q     <= '0;
`ifdef SET_DISP_TIMEOUT_EN
            wait_cnt_q <= '0;
            job_to_q   <= 1'b0;
            to_seen_q  <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            pat_addr_q <= pat_addr_d;
            central_q  <= central_d;
            radius_q   <= radius_d;
            mode_q     <= mode_d;
            expected_q <= expected_d;
            cand_q     <= cand_d;
            set_en_q   <= set_en_d;
            run_busy_q <= run_busy_d;
            done_q     <= done_d;
            aborted_q  <= aborted_d;
            err_q      <= err_d;
            fail_q     <= fail_d;
`ifdef SET_DISP_TIMEOUT_EN
            wait_cnt_q <= wait_cnt_d;
            job_to_q   <= job_to_d;
            to_seen_q  <= to_seen_d;
`endif
        end
    end

    assign pat_addr    = pat_addr_q;
    assign set_en      = set_en_q;
    assign set_central = central_q;
    assign set_radius  = radius_q;
    assign set_mode    = mode_q;
    assign run_busy    = run_busy_q;
    assign done        = done_q;
    assign aborted     = aborted_q;
    assign err_cnt     = err_q;
    assign fail_idx    = fail_q;
`ifdef SET_DISP_TIMEOUT_EN
    assign timeout_seen = to_seen_q;
`endif

endmodule

// File: tb/tb_set_dispatcher.sv
// Bench for set_dispatcher: ROM model, stub SET engine, table rows, random runs and reset corner.
module tb_set_dispatcher;

    localparam int NUM  = 64;
    localparam int MAXE = 10;
`ifdef SET_DISP_TIMEOUT_EN
    localparam int TB_TIMEOUT = 50;
`else
    localparam int TB_TIMEOUT = 4095;
`endif

    logic        clk;
    logic        rst_n, start;
    logic [1:0]  mode;
    logic [5:0]  pat_addr;
    logic [23:0] pat_central;
    logic [11:0] pat_radius;
    logic [7:0]  pat_expected;
    logic        set_en;
    logic [23:0] set_central;
    logic [11:0] set_radius;
    logic [1:0]  set_mode;
    logic        set_busy, set_valid;
    logic [7:0]  set_candidate;
    logic        run_busy, done, aborted;
    logic [6:0]  err_cnt;
    logic [5:0]  fail_idx;
    logic        to_seen;

    set_dispatcher #(
        .NUM_PAT(NUM), .AW(6), .MAX_ERR(MAXE), .TIMEOUT(TB_TIMEOUT)
    ) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .mode(mode), .pat_addr(pat_addr),
        .pat_central(pat_central), .pat_radius(pat_radius), .pat_expected(pat_expected),
        .set_en(set_en), .set_central(set_central), .set_radius(set_radius),
        .set_mode(set_mode), .set_busy(set_busy), .set_valid(set_valid),
        .set_candidate(set_candidate), .run_busy(run_busy), .done(done), .aborted(aborted),
        .err_cnt(err_cnt),
`ifdef SET_DISP_TIMEOUT_EN
        .timeout_seen(to_seen),
`endif
        .fail_idx(fail_idx)
    );

`ifndef SET_DISP_TIMEOUT_EN
    assign to_seen = 1'b0;
`endif

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Synchronous pattern ROM, one cycle read latency.
    logic [23:0] rom_central [NUM];
    logic [11:0] rom_radius  [NUM];
    logic [7:0]  rom_expected[NUM];
    always @(posedge clk) begin
        pat_central  <= rom_central[pat_addr];
        pat_radius   <= rom_radius[pat_addr];
        pat_expected <= rom_expected[pat_addr];
    end

    // resp_kind: 0 = correct answer, 1 = wrong answer, 2 = never answers
    int resp_kind[NUM];
    int lat_cfg, busy_cfg, run_id, poke_req;
    bit stub_on;
    int stub_bad;

    initial begin : stub
        int seen_run, stub_job, poke_ack, j;
        logic [23:0] c;
        logic [11:0] r;
        seen_run = 0; stub_job = 0; poke_ack = 0; stub_bad = 0;
        set_busy = 0; set_valid = 0; set_candidate = 0;
        forever begin
            @(posedge clk); #1;
            if (seen_run != run_id) begin
                seen_run = run_id;
                stub_job = 0;
            end
            if (poke_ack != poke_req) begin
                poke_ack = poke_req;
                set_valid = 1; set_candidate = 8'h5A;
                @(posedge clk); #1;
                set_valid = 0;
            end else if (stub_on && set_en) begin
                j = (stub_job < NUM) ? stub_job : NUM - 1;
                stub_job++;
                c = set_central; r = set_radius;
                if (c !== rom_central[j] || r !== rom_radius[j]) stub_bad++;
                if (resp_kind[j] != 2) begin
                    set_busy = 1;
                    for (int k = 0; k < lat_cfg && stub_on; k++) begin
                        @(posedge clk); #1;
                        if (stub_on && (set_central !== c || set_radius !== r)) stub_bad++;
                    end
                    if (stub_on) begin
                        set_valid = 1;
                        set_candidate = (resp_kind[j] == 1) ? ~rom_expected[j] : rom_expected[j];
                        @(posedge clk); #1;
                        set_valid = 0;
                    end
                    for (int k = 0; k < busy_cfg && stub_on; k++) begin
                        @(posedge clk); #1;
                    end
                    set_busy = 0;
                end
            end
        end
    end

    // set_en monitor: pulse count, pulses longer than one cycle, pulses issued under busy.
    int en_pulses, en_long, en_busy;
    logic en_prev, busy_at_edge;
    initial begin
        en_pulses = 0; en_long = 0; en_busy = 0; en_prev = 0;
    end
    always @(posedge clk) busy_at_edge <= set_busy;
    always @(negedge clk) begin
        if (set_en === 1'b1) begin
            if (en_prev) en_long++;
            else en_pulses++;
            if (busy_at_edge && !en_prev) en_busy++;
        end
        en_prev = (set_en === 1'b1);
    end

    int n_cmp, n_fail;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    int r_err, r_fail, r_abort, r_done, r_done0, r_jobs, r_long, r_busyv, r_bad;
    int r_mode, r_busy0, r_busy_end, r_to;

    task automatic run_once(input logic [1:0] md, input int lat, input int bsy, input bit mid);
        int b_en, b_long, b_busy, b_bad, cyc;
        lat_cfg = lat; busy_cfg = bsy; run_id++;
        b_en = en_pulses; b_long = en_long; b_busy = en_busy; b_bad = stub_bad;
        @(posedge clk); #1;
        mode = md; start = 1;
        @(posedge clk); #1;
        start = 0;
        r_mode = set_mode; r_busy0 = run_busy; r_done0 = done;
        if (mid) begin
            repeat (30) @(posedge clk);
            #1; mode = ~md; start = 1;
            @(posedge clk); #1;
            start = 0;
        end
        cyc = 0;
        while (!done && cyc < 30000) begin
            @(posedge clk); #1;
            cyc++;
        end
        r_done = done; r_err = err_cnt; r_fail = fail_idx; r_abort = aborted; r_to = to_seen;
        repeat (20) @(posedge clk);
        #1;
        r_busy_end = run_busy;
        r_jobs = en_pulses - b_en; r_long = en_long - b_long;
        r_busyv = en_busy - b_busy; r_bad = stub_bad - b_bad;
    endtask

    task automatic check_run(input string tag, input logic [1:0] md, input int e_err,
                             input int e_fail, input int e_abort, input int e_jobs, input int e_to);
        check({tag, ".done"}, r_done, 1);
        check({tag, ".done_at_start"}, r_done0, 0);
        check({tag, ".err_cnt"}, r_err, e_err);
        check({tag, ".fail_idx"}, r_fail, e_fail);
        check({tag, ".aborted"}, r_abort, e_abort);
        check({tag, ".jobs"}, r_jobs, e_jobs);
        check({tag, ".en_width"}, r_long, 0);
        check({tag, ".en_under_busy"}, r_busyv, 0);
        check({tag, ".operands"}, r_bad, 0);
        check({tag, ".set_mode"}, r_mode, md);
        check({tag, ".run_busy_start"}, r_busy0, 1);
        check({tag, ".run_busy_end"}, r_busy_end, 0);
        check({tag, ".timeout_seen"}, r_to, e_to);
    endtask

    // Reference: walk patterns in order, any non-correct answer is a mismatch, stop at MAXE.
    task automatic model(output int e_err, output int e_fail, output int e_abort,
                         output int e_jobs, output int e_to);
        e_err = 0; e_fail = 0; e_abort = 0; e_jobs = 0; e_to = 0;
        for (int i = 0; i < NUM; i++) begin
            e_jobs++;
            if (resp_kind[i] == 2) e_to = 1;
            if (resp_kind[i] != 0) begin
                if (e_err == 0) e_fail = i;
                if (e_err < 64) e_err++;
                if (MAXE != 0 && e_err == MAXE) begin
                    e_abort = 1;
                    break;
                end
            end
        end
    endtask

    typedef struct {
        logic [63:0] mask;
        logic [1:0]  md;
        int          lat;
        int          bsy;
        bit          mid;
        int          e_err;
        int          e_fail;
        int          e_abort;
        int          e_jobs;
    } row_t;

    row_t rows[6];
    logic [60:0] zero_vec;
    assign zero_vec = {set_en, run_busy, done, aborted, err_cnt, fail_idx, pat_addr,
                       set_central, set_radius, set_mode};

    initial begin : main
        int e_err, e_fail, e_abort, e_jobs, e_to, cyc, b_en;
        logic [63:0] rmask;
        n_cmp = 0; n_fail = 0; run_id = 0; poke_req = 0; stub_on = 1;
        lat_cfg = 1; busy_cfg = 0;
        rst_n = 0; start = 0; mode = 0;
        for (int i = 0; i < NUM; i++) begin
            rom_central[i]  = {i[5:0], 18'($urandom)};
            rom_radius[i]   = 12'($urandom);
            rom_expected[i] = 8'($urandom);
            resp_kind[i]    = 0;
        end
        rom_central[0] = 24'h448600; rom_radius[0] = 12'h330; rom_expected[0] = 8'h15;

        rows[0] = '{64'h0, 2'd0, 20, 0, 1'b0, 0, 0, 0, 64};
        rows[1] = '{64'h0000_0100_0000_0008, 2'd1, 3, 7, 1'b0, 2, 3, 0, 64};
        rows[2] = '{64'hFFFF_FFFF_FFFF_FFFF, 2'd2, 1, 0, 1'b0, 10, 0, 1, 10};
        rows[3] = '{64'h8000_0000_0000_0000, 2'd3, 2, 1, 1'b1, 1, 63, 0, 64};
        rows[4] = '{64'h0000_0000_0000_7FE0, 2'd1, 1, 0, 1'b0, 10, 5, 1, 15};
        rows[5] = '{64'h0000_0000_1FF0_0001, 2'd2, 4, 2, 1'b0, 10, 0, 1, 29};

        repeat (2) @(posedge clk);
        #1;
        check("reset_state", 64'(zero_vec), 64'h0);
        rst_n = 1;

        for (int r = 0; r < 6; r++) begin
            for (int i = 0; i < NUM; i++) resp_kind[i] = rows[r].mask[i] ? 1 : 0;
            run_once(rows[r].md, rows[r].lat, rows[r].bsy, rows[r].mid);
            check_run($sformatf("row%0d", r), rows[r].md, rows[r].e_err, rows[r].e_fail,
                      rows[r].e_abort, rows[r].e_jobs, 0);
        end

        for (int r = 0; r < 6; r++) begin
            for (int i = 0; i < NUM; i++)
                resp_kind[i] = ($urandom_range(0, (r % 3 == 2) ? 1 : 20) == 0) ? 1 : 0;
            model(e_err, e_fail, e_abort, e_jobs, e_to);
            run_once(2'($urandom_range(0, 3)), $urandom_range(1, 12), $urandom_range(0, 4), 1'b0);
            check_run($sformatf("rand%0d", r), 2'(r_mode), e_err, e_fail, e_abort, e_jobs, e_to);
        end

        // Asynchronous reset while a job is outstanding, then a stray valid.
        for (int i = 0; i < NUM; i++) resp_kind[i] = 0;
        lat_cfg = 15; busy_cfg = 0; run_id++;
        b_en = en_pulses;
        @(posedge clk); #1;
        mode = 2'd3; start = 1;
        @(posedge clk); #1;
        start = 0;
        cyc = 0;
        while (en_pulses == b_en && cyc < 100) begin
            @(posedge clk); #1;
            cyc++;
        end
        check("rst.job_issued", en_pulses - b_en, 1);
        repeat (3) @(posedge clk);
        #3;
        rst_n = 0; stub_on = 0;
        #1;
        check("rst.async_clear", 64'(zero_vec), 64'h0);
        @(posedge clk); #1;
        rst_n = 1;
        b_en = en_pulses;
        repeat (2) @(posedge clk);
        #1;
        poke_req++;
        repeat (30) @(posedge clk);
        #1;
        check("rst.stray_valid", 64'(zero_vec), 64'h0);
        check("rst.no_jobs", en_pulses - b_en, 0);
        stub_on = 1;
        run_once(2'd0, 5, 0, 1'b0);
        check_run("post_rst", 2'd0, 0, 0, 0, 64, 0);

`ifdef SET_DISP_TIMEOUT_EN
        for (int i = 0; i < NUM; i++) resp_kind[i] = 0;
        resp_kind[2] = 2;
        model(e_err, e_fail, e_abort, e_jobs, e_to);
        run_once(2'd1, 3, 0, 1'b0);
        check_run("timeout", 2'd1, e_err, e_fail, e_abort, e_jobs, e_to);
        check("timeout.err_one", r_err, 1);
        check("timeout.fail_two", r_fail, 2);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/set_dispatcher.md
Name: set_dispatcher

Overview:
- Host-side driver for the SET circle-candidate engine: the initiator end of the SET en/busy/valid handshake.
- Walks a pattern ROM (central, radius, expected) and issues one job per pattern to SET in the selected mode.
- Captures each candidate, compares it against the expected value, and reports error count and first failing index.
- Sits between a synchronous pattern ROM and the SET instance; self-checking in silicon/FPGA bring-up.

Parameters:
- NUM_PAT, 64, number of patterns walked per run (1..64)
- AW, 6, pattern ROM address width
- MAX_ERR, 10, error count at which the run aborts early (0 = never abort)
- TIMEOUT, 4095, per-job cycle limit (used only with the optional feature)

Ports:
- clk  in  1  clock, all state updates on rising edge
- rst_n  in  1  asynchronous active-low reset
- start  in  1  one-cycle run request; honoured in IDLE or DONE only
- mode  in  2  SET mode for the run (00 area, 01 union, 10 diff, 11 intersect); latched on start
- pat_addr  out  AW  pattern ROM address
- pat_central  in  24  ROM data; 1-cycle read latency
- pat_radius  in  12  ROM data; 1-cycle read latency
- pat_expected  in  8  ROM data; 1-cycle read latency
- set_en  out  1  job strobe to SET, exactly one cycle per job
- set_central  out  24  to SET; held stable from en until valid is sampled
- set_radius  out  12  to SET; held stable from en until valid is sampled
- set_mode  out  2  latched run mode
- set_busy  in  1  SET busy
- set_valid  in  1  SET result valid
- set_candidate  in  8  SET result
- run_busy  out  1  high in any state other than IDLE/DONE
- done  out  1  high in DONE
- aborted  out  1  run ended by the MAX_ERR limit
- err_cnt  out  7  mismatches in the current run
- fail_idx  out  AW  index of the first mismatch; valid when err_cnt != 0

Behaviour:
- Reset, asynchronous: state=IDLE.
  - Outputs set_en, run_busy, done, aborted, err_cnt, fail_idx, pat_addr, set_central, set_radius and set_mode all 0.
  - A reset mid-run abandons the job immediately. Any later set_valid is ignored until the next start.
- All outputs are registered.
- FSM states: IDLE, FETCH, LOAD, ISSUE, WAIT, CHECK, DONE.
- IDLE/DONE --start--> FETCH.
  - Clears idx, err_cnt, fail_idx, aborted and done.
  - Latches mode into set_mode.
- FETCH: pat_addr=idx. Next state is LOAD.
- LOAD: capture pat_central and pat_radius into set_central and set_radius; hold pat_expected internally. Next state is ISSUE.
- ISSUE: wait while set_busy=1. When set_busy=0, register set_en=1 and go to WAIT. set_en drops on the following edge.
- WAIT: set_valid is sampled only when set_en=0. On set_valid=1, capture set_candidate and go to CHECK. Latency is unbounded unless the optional feature is enabled.
- CHECK: if the candidate differs from expected, increment err_cnt; on the first mismatch, also record fail_idx=idx.
  - If MAX_ERR!=0 and the new err_cnt==MAX_ERR: set aborted=1 and go to DONE.
  - Else if idx==NUM_PAT-1: go to DONE.
  - Else: increment idx and go to FETCH.
- Minimum per-job overhead is 5 cycles plus SET latency.
- start is ignored in FETCH..CHECK.
- set_valid is ignored outside WAIT.
- err_cnt saturates at 64.

Optional Feature:
- Macro SET_DISP_TIMEOUT_EN.
- Defined: a per-job counter is cleared on entry to WAIT. If it reaches TIMEOUT with no valid, the job counts as a mismatch and goes through CHECK (same abort and fail_idx rules), and the sticky output timeout_seen (1 bit, reset 0, cleared on start) is set.
- Undefined: no counter and no timeout_seen port; WAIT waits indefinitely.

Test Plan:
- Single pattern: NUM_PAT=1; ROM[0] = central 0x448600, radius 0x330, expected 0x15; stub SET returns 0x15 after 20 cycles -> set_en high exactly 1 cycle, done=1, err_cnt=0, aborted=0.
- Busy hold-off: stub holds set_busy=1 for 7 cycles after LOAD -> set_en rises on the first edge with busy=0, and set_central/set_radius remain stable until valid.
- Mismatch tracking: 64 patterns with stub errors at indices 3 and 40 -> err_cnt=2, fail_idx=3, done=1 after index 63.
- Early abort: stub always returns 0xFF against expected 0x00 with MAX_ERR=10 -> aborted=1 and done=1 after index 9, with no further set_en.
- Async reset mid-WAIT: assert rst_n low, release, then pulse set_valid -> outputs stay at reset values and state stays IDLE; a following start runs cleanly from idx 0.
- With SET_DISP_TIMEOUT_EN and TIMEOUT=50: stub never asserts valid on pattern 2 -> timeout_seen=1, err_cnt=1, fail_idx=2, and the run continues to pattern 3.
